// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the scan-code decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_FRAME_LEN = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_EXT   = 2'd2
  } dec_state_t;

  // True when start=0, stop=1 and data+parity hold an odd number of ones.
  function automatic logic frame_ok(input logic [10:0] f);
    return ~f[0] & f[10] & (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Set-2 scan code to ASCII: letters lowercase, digits, space; anything else 0x00.
module ps2_scan2ascii (
  input  logic [7:0] i_scan,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = 8'h00;
    case (i_scan)
      8'h1C: o_ascii = 8'h61;  8'h32: o_ascii = 8'h62;  8'h21: o_ascii = 8'h63;
      8'h23: o_ascii = 8'h64;  8'h24: o_ascii = 8'h65;  8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67;  8'h33: o_ascii = 8'h68;  8'h43: o_ascii = 8'h69;
      8'h3B: o_ascii = 8'h6A;  8'h42: o_ascii = 8'h6B;  8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D;  8'h31: o_ascii = 8'h6E;  8'h44: o_ascii = 8'h6F;
      8'h4D: o_ascii = 8'h70;  8'h15: o_ascii = 8'h71;  8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73;  8'h2C: o_ascii = 8'h74;  8'h3C: o_ascii = 8'h75;
      8'h2A: o_ascii = 8'h76;  8'h1D: o_ascii = 8'h77;  8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79;  8'h1A: o_ascii = 8'h7A;
      8'h45: o_ascii = 8'h30;  8'h16: o_ascii = 8'h31;  8'h1E: o_ascii = 8'h32;
      8'h26: o_ascii = 8'h33;  8'h25: o_ascii = 8'h34;  8'h2E: o_ascii = 8'h35;
      8'h36: o_ascii = 8'h36;  8'h3D: o_ascii = 8'h37;  8'h3E: o_ascii = 8'h38;
      8'h46: o_ascii = 8'h39;
      8'h29: o_ascii = 8'h20;
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver plus make/break decoder tracking the single held key.
// Decoder state is exported on o_dec_state for observation.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_num,
  output logic [7:0] asc_num,
  output logic [7:0] key_times,
  output logic       key_pressed,
  output logic       frame_err,
  output logic [1:0] o_dec_state
);

  localparam int             TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     BIT_LAST = 4'(PS2_FRAME_LEN - 1);

  logic          r_clk_s1, r_clk_s2, r_clk_d;
  logic          r_dat_s1, r_dat_s2;
  logic          w_fall;
  logic [3:0]    r_bit_cnt;
  logic [10:0]   r_shift;
  logic [TW-1:0] r_to_cnt;
  logic          r_stop_seen;
  logic          r_byte_valid;
  logic [7:0]    r_byte;
  logic          r_frame_err;
  dec_state_t    r_state;
  logic [7:0]    r_key_num;
  logic [7:0]    r_key_times;
  logic          r_key_pressed;

  // Synchronizers preset to the PS/2 idle level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_s2;

  // r_byte_valid is a one-cycle strobe with r_byte; the decoder has no
  // back-pressure, so every strobe is consumed on the cycle it is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_to_cnt     <= '0;
      r_stop_seen  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_stop_seen  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_shift  <= {r_dat_s2, r_shift[10:1]};
        r_to_cnt <= '0;
        if (r_bit_cnt == BIT_LAST) begin
          r_bit_cnt   <= '0;
          r_stop_seen <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == TO_LAST) begin
          r_bit_cnt   <= '0;
          r_to_cnt    <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
      if (r_stop_seen) begin
        if (frame_ok(r_shift)) begin
          r_byte_valid <= 1'b1;
          r_byte       <= r_shift[8:1];
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // EXT decodes the following byte exactly as IDLE would.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_key_num     <= '0;
      r_key_times   <= '0;
      r_key_pressed <= 1'b0;
    end else if (r_byte_valid) begin
      case (r_state)
        ST_IDLE, ST_EXT: begin
          if (r_byte == PS2_EXT) begin
            r_state <= ST_EXT;
          end else if (r_byte == PS2_BREAK) begin
            r_state <= ST_BREAK;
          end else begin
            r_state <= ST_IDLE;
            if (!(r_key_pressed && (r_byte == r_key_num))) begin
              r_key_num     <= r_byte;
              r_key_pressed <= 1'b1;
              r_key_times   <= r_key_times + 8'd1;
            end
          end
        end
        ST_BREAK: begin
          r_state <= ST_IDLE;
          if (r_byte == r_key_num) begin
            r_key_num     <= 8'h00;
            r_key_pressed <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ps2_scan2ascii u_scan2ascii (
    .i_scan  (r_key_num),
    .o_ascii (asc_num)
  );

  assign key_num     = r_key_num;
  assign key_times   = r_key_times;
  assign key_pressed = r_key_pressed;
  assign frame_err   = r_frame_err;
  assign o_dec_state = r_state;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: PS/2 frames driven bit by bit, outputs checked by immediate assertions.
module tb_ps2_key_ctrl;
  import ps2_pkg::*;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_num, asc_num, key_times;
  logic       key_pressed, frame_err;
  logic [1:0] dec_state;

  int n_asserts = 0;
  int n_fail    = 0;
  int err_cnt   = 0;
  int err_base;

  ps2_key_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_num     (key_num),
    .asc_num     (asc_num),
    .key_times   (key_times),
    .key_pressed (key_pressed),
    .frame_err   (frame_err),
    .o_dec_state (dec_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_keys(input string tag, input logic [7:0] num, input logic [7:0] asc,
                          input logic [7:0] times, input logic pressed);
    chk({tag, ".key_num"}, key_num, num);
    chk({tag, ".asc_num"}, asc_num, asc);
    chk({tag, ".key_times"}, key_times, times);
    chk({tag, ".key_pressed"}, {7'd0, key_pressed}, {7'd0, pressed});
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par,
                                             input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic settle();
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(make_frame(d, 1'b0, 1'b1), 11);
    settle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] f;
    do_reset();
    chk_keys("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("reset.frame_err", {7'd0, frame_err}, 8'h00);
    chk("reset.state", {6'd0, dec_state}, 8'(ST_IDLE));

    // First 0x1C: stop bit driven by hand to check the two-cycle update latency.
    f = make_frame(8'h1C, 1'b0, 1'b1);
    send_bits(f, 10);
    ps2_data = f[10];
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("lat.before", {7'd0, key_pressed}, 8'h00);
    @(negedge clk);
    #1 chk("lat.after", {7'd0, key_pressed}, 8'h01);
    ps2_clk = 1'b1;
    settle();
    chk_keys("press_1c", 8'h1C, 8'h61, 8'h01, 1'b1);

    // Typematic repeats then release.
    send_frame(8'h1C);
    send_frame(8'h1C);
    chk_keys("typematic", 8'h1C, 8'h61, 8'h01, 1'b1);
    send_frame(PS2_BREAK);
    chk("break.state", {6'd0, dec_state}, 8'(ST_BREAK));
    send_frame(8'h1C);
    chk_keys("release_1c", 8'h00, 8'h00, 8'h01, 1'b0);

    // Rollover to a second key; stale release of the first is ignored.
    do_reset();
    send_frame(8'h1C);
    send_frame(8'h32);
    chk_keys("rollover", 8'h32, 8'h62, 8'h02, 1'b1);
    send_frame(PS2_BREAK);
    send_frame(8'h1C);
    chk_keys("stale_break", 8'h32, 8'h62, 8'h02, 1'b1);

    // Rejected frames: bad parity, then stop = 0.
    err_base = err_cnt;
    send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
    settle();
    chk("bad_parity.err", 8'(err_cnt - err_base), 8'h01);
    chk_keys("bad_parity", 8'h32, 8'h62, 8'h02, 1'b1);
    err_base = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
    settle();
    chk("bad_stop.err", 8'(err_cnt - err_base), 8'h01);
    chk_keys("bad_stop", 8'h32, 8'h62, 8'h02, 1'b1);
    send_frame(PS2_BREAK);
    send_frame(8'h32);
    chk_keys("release_32", 8'h00, 8'h00, 8'h02, 1'b0);

    // 256 press/release pairs of '0': counter wraps to zero.
    do_reset();
    err_base = err_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'h45);
      chk("wrap.key_num", key_num, 8'h45);
      chk("wrap.asc_num", asc_num, 8'h30);
      chk("wrap.key_times", key_times, 8'(i + 1));
      send_frame(PS2_BREAK);
      send_frame(8'h45);
    end
    chk_keys("wrap_end", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("wrap.no_err", 8'(err_cnt - err_base), 8'h00);

    // Extended key E0 75, then E0 F0 75.
    send_frame(PS2_EXT);
    chk("ext.state", {6'd0, dec_state}, 8'(ST_EXT));
    send_frame(8'h75);
    chk_keys("ext_press", 8'h75, 8'h00, 8'h01, 1'b1);
    send_frame(PS2_EXT);
    send_frame(PS2_BREAK);
    send_frame(8'h75);
    chk_keys("ext_release", 8'h00, 8'h00, 8'h01, 1'b0);

    // Stall mid-frame: timeout aborts it with one error pulse.
    err_base = err_cnt;
    send_bits(make_frame(8'h29, 1'b0, 1'b1), 5);
    ps2_data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    #1;
    chk("stall.err", 8'(err_cnt - err_base), 8'h01);
    chk_keys("stall_hold", 8'h00, 8'h00, 8'h01, 1'b0);
    send_frame(8'h29);
    chk_keys("after_stall", 8'h29, 8'h20, 8'h02, 1'b1);
    send_frame(PS2_BREAK);
    send_frame(8'h29);

    // Reset mid-frame: partial frame dropped silently.
    err_base = err_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 5);
    ps2_data = 1'b1;
    do_reset();
    chk("rst_mid.err", 8'(err_cnt - err_base), 8'h00);
    chk_keys("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0);
    send_frame(8'h29);
    chk_keys("after_rst", 8'h29, 8'h20, 8'h01, 1'b1);
    chk("after_rst.err", 8'(err_cnt - err_base), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000; idle clk cycles inside a frame before the receiver aborts it.
REQ-002 SHALL have port clk, input, 1, system clock; sole clock domain.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port ps2_clk, input, 1, raw keyboard clock; asynchronous to clk.
REQ-005 SHALL have port ps2_data, input, 1, raw keyboard data; asynchronous to clk.
REQ-006 SHALL have port key_num, output, 8, scan code of the currently held key; 0x00 when no key is held.
REQ-007 SHALL have port asc_num, output, 8, ASCII code of key_num; 0x00 when unmapped or when key_num = 0x00.
REQ-008 SHALL have port key_times, output, 8, count of distinct key presses since reset.
REQ-009 SHALL have port key_pressed, output, 1, high while a key is held.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a rejected frame.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, then detect a ps2_clk falling edge from the last synchronized stage and one further delayed copy.
REQ-012 SHALL sample synchronized ps2_data on each detected falling edge into an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
REQ-013 SHALL accept a frame only if start = 0, the 8 data bits plus parity contain an odd number of 1s, and stop = 1.
REQ-014 SHALL set the internal byte-valid strobe at edge N+1 when the stop bit is captured at edge N; SHALL update key_num, key_times and key_pressed at edge N+2.
REQ-015 SHALL, on a rejected frame, pulse frame_err at edge N+1 and leave every key output unchanged.
REQ-016 SHALL clear the bit counter and pulse frame_err when the bit counter is nonzero and TIMEOUT_CYCLES clk cycles pass with no falling edge.
REQ-017 SHALL run a decoder FSM with three states: IDLE, BREAK and EXT.
REQ-018 SHALL, in the decoder, handle byte 0xE0 by going to EXT; the next byte SHALL then be handled as if received in IDLE.
REQ-019 SHALL, in the decoder, handle byte 0xF0 by going to BREAK from IDLE or EXT.
REQ-020 SHALL, in BREAK, take the next byte B and return to IDLE; if B = key_num, it SHALL clear key_num to 0x00 and key_pressed to 0; otherwise no outputs SHALL change.
REQ-021 SHALL, in IDLE, treat a make code M that equals key_num while key_pressed = 1 as a typematic repeat: no change to any output.
REQ-022 SHALL, in IDLE, treat any other make code M as a new press: key_num <= M, key_pressed <= 1, key_times <= key_times + 1.
REQ-023 SHALL increment key_times modulo 256 (0xFF + 1 = 0x00) with no saturation.
REQ-024 SHALL derive asc_num combinationally from registered key_num; letters map to lowercase, digits to 0x30-0x39, space to 0x20; all other codes map to 0x00.
REQ-025 SHALL never start a new frame before the current one completes or times out; falling edges beyond the stop bit SHALL begin the next frame.

Reset
REQ-026 SHALL, while rst = 1 at a clk edge, clear key_num, key_times, key_pressed, frame_err, the bit counter, the shift register and the timeout counter to 0, and set the FSM to IDLE.
REQ-027 SHALL preset synchronizer flops to 1, the PS/2 idle level, so that no false falling edge occurs after reset.
REQ-028 SHALL discard a partially received frame when rst is asserted mid-frame; reception SHALL resume on the next start bit after rst falls.

Structure
REQ-029 SHALL keep PS/2 constants 0xF0, 0xE0 and the frame length of 11, plus the FSM state encoding, in a shared package ps2_pkg.
REQ-030 SHALL put the scan-code-to-ASCII table in one combinational sub-module ps2_scan2ascii (8-bit in, 8-bit out).
REQ-031 SHALL connect key_num, asc_num and key_times directly to the seven-segment display stage inputs of the same names.

Verification
REQ-032 SHALL cover: frame 0x1C -> key_num = 0x1C, asc_num = 0x61, key_pressed = 1, key_times = 0x01 two clk cycles after the stop bit.
REQ-033 SHALL cover: 0x1C, 0x1C, 0x1C, then F0 1C -> key_times = 0x01, then key_num = 0x00, asc_num = 0x00, key_pressed = 0.
REQ-034 SHALL cover: 0x1C then 0x32 without release -> key_num = 0x32, asc_num = 0x62, key_times = 0x02; a following F0 1C leaves all outputs unchanged.
REQ-035 SHALL cover: a frame with bad parity, and a separate frame with stop = 0 -> frame_err pulses once for each and outputs hold.
REQ-036 SHALL cover: 256 press/release pairs of 0x45 -> key_times wraps to 0x00 with asc_num = 0x30 during each press.
REQ-037 SHALL cover: 5 bits of a frame followed by a TIMEOUT_CYCLES stall, and separately rst mid-frame -> a frame_err pulse (stall case only), then the next full frame 0x29 decodes with asc_num = 0x20.
